// File: rtl/star_bbox_finder.sv
// Bounding-box finder: from a bright seed pixel, probes the frame RAM right, left, down and up
// to find the star's extremes and centre, then reports them with a one-cycle done pulse.
module star_bbox_finder #(
  parameter int unsigned X_W       = 3,
  parameter int unsigned Y_W       = 3,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned PIX_W     = 3,
  parameter int unsigned X_RES     = 6,
  parameter int unsigned Y_RES     = 6,
  parameter int unsigned THRESHOLD = 0,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [PIX_W-1:0]  rd_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_o,
  output logic [X_W-1:0]    left_o,
  output logic [X_W-1:0]    right_o,
  output logic [X_W-1:0]    mid_x_o,
  output logic [Y_W-1:0]    top_o,
  output logic [Y_W-1:0]    bottom_o,
  output logic [Y_W-1:0]    mid_y_o
);

  localparam logic [X_W-1:0]   XMax = X_W'(X_RES - 1);
  localparam logic [Y_W-1:0]   YMax = Y_W'(Y_RES - 1);
  localparam logic [PIX_W-1:0] Thr  = PIX_W'(THRESHOLD);
  localparam logic [1:0]       Last = 2'(RD_LAT);

  typedef enum logic [2:0] {StIdle, StSeed, StRight, StLeft, StDown, StUp, StDone} state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x0_q, x0_d, px_q, px_d, l_q, l_d, r_q, r_d;
  logic [Y_W-1:0] y0_q, y0_d, py_q, py_d, t_q, t_d, b_q, b_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [X_W-1:0] left_q, left_d, right_q, right_d, mid_x_q, mid_x_d;
  logic [Y_W-1:0] top_q, top_d, bottom_q, bottom_d, mid_y_q, mid_y_d;

  logic adv, bright;
  logic go_right, go_left, go_down, go_up, go_done, box_ok;

  assign adv    = (cnt_q == Last);
  assign bright = (rd_data_i > Thr);

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    px_d     = px_q;
    py_d     = py_q;
    cnt_d    = cnt_q + 2'd1;
    l_d      = l_q;
    r_d      = r_q;
    t_d      = t_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    left_d   = left_q;
    right_d  = right_q;
    mid_x_d  = mid_x_q;
    top_d    = top_q;
    bottom_d = bottom_q;
    mid_y_d  = mid_y_q;
    go_right = 1'b0;
    go_left  = 1'b0;
    go_down  = 1'b0;
    go_up    = 1'b0;
    go_done  = 1'b0;
    box_ok   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 2'd0;
        if (start_i) begin
          x0_d   = x_i;
          y0_d   = y_i;
          busy_d = 1'b1;
          if (x_i > XMax || y_i > YMax) begin
            go_done = 1'b1;
          end else begin
            state_d = StSeed;
            px_d    = x_i;
            py_d    = y_i;
          end
        end
      end
      StSeed: if (adv) begin
        if (!bright) begin
          go_done = 1'b1;
        end else begin
          l_d      = x0_q;
          r_d      = x0_q;
          t_d      = y0_q;
          b_d      = y0_q;
          go_right = 1'b1;
        end
      end
      StRight: if (adv) begin
        if (bright) r_d = px_q;
        if (!bright || px_q == XMax) go_left = 1'b1;
        else begin
          px_d  = px_q + 1'b1;
          cnt_d = 2'd0;
        end
      end
      StLeft: if (adv) begin
        if (bright) l_d = px_q;
        if (!bright || px_q == '0) go_down = 1'b1;
        else begin
          px_d  = px_q - 1'b1;
          cnt_d = 2'd0;
        end
      end
      StDown: if (adv) begin
        if (bright) b_d = py_q;
        if (!bright || py_q == YMax) go_up = 1'b1;
        else begin
          py_d  = py_q + 1'b1;
          cnt_d = 2'd0;
        end
      end
      StUp: if (adv) begin
        if (bright) t_d = py_q;
        if (!bright || py_q == '0) begin
          go_done = 1'b1;
          box_ok  = 1'b1;
        end else begin
          py_d  = py_q - 1'b1;
          cnt_d = 2'd0;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
      default: state_d = StIdle;
    endcase

    // Phases with no pixels to probe are skipped in the same cycle, so probes run back to back.
    if (go_right) begin
      if (x0_q == XMax) go_left = 1'b1;
      else begin
        state_d = StRight;
        px_d    = x0_q + 1'b1;
        py_d    = y0_q;
        cnt_d   = 2'd0;
      end
    end
    if (go_left) begin
      if (x0_q == '0) go_down = 1'b1;
      else begin
        state_d = StLeft;
        px_d    = x0_q - 1'b1;
        py_d    = y0_q;
        cnt_d   = 2'd0;
      end
    end
    if (go_down) begin
      px_d = X_W'(({1'b0, l_d} + {1'b0, r_d}) >> 1);
      if (y0_q == YMax) go_up = 1'b1;
      else begin
        state_d = StDown;
        py_d    = y0_q + 1'b1;
        cnt_d   = 2'd0;
      end
    end
    if (go_up) begin
      if (y0_q == '0) begin
        go_done = 1'b1;
        box_ok  = 1'b1;
      end else begin
        state_d = StUp;
        py_d    = y0_q - 1'b1;
        cnt_d   = 2'd0;
      end
    end
    if (go_done) begin
      state_d = StDone;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      valid_d = box_ok;
      if (box_ok) begin
        left_d   = l_d;
        right_d  = r_d;
        top_d    = t_d;
        bottom_d = b_d;
        mid_x_d  = X_W'(({1'b0, l_d} + {1'b0, r_d}) >> 1);
        mid_y_d  = Y_W'(({1'b0, t_d} + {1'b0, b_d}) >> 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      y0_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      cnt_q    <= '0;
      l_q      <= '0;
      r_q      <= '0;
      t_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      mid_x_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
      mid_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      px_q     <= px_d;
      py_q     <= py_d;
      cnt_q    <= cnt_d;
      l_q      <= l_d;
      r_q      <= r_d;
      t_q      <= t_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      left_q   <= left_d;
      right_q  <= right_d;
      mid_x_q  <= mid_x_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      mid_y_q  <= mid_y_d;
    end
  end

  // Truncating each operand to ADDR_W gives the same low bits as the full-width product.
  assign rd_addr_o = ADDR_W'(py_q) * ADDR_W'(X_RES) + ADDR_W'(px_q);
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign valid_o   = valid_q;
  assign left_o    = left_q;
  assign right_o   = right_q;
  assign mid_x_o   = mid_x_q;
  assign top_o     = top_q;
  assign bottom_o  = bottom_q;
  assign mid_y_o   = mid_y_q;

endmodule

// File: tb/tb_star_bbox_finder.sv
// Bench for star_bbox_finder: two instances (read latency 1 and 3) share one image memory.
module tb_star_bbox_finder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [2:0] x_in = '0, y_in = '0;

  logic [5:0] addr1, addr3;
  logic [2:0] rd1, p3a, p3b, p3c;
  logic       busy1, done1, valid1, busy3, done3, valid3;
  logic [2:0] l1, r1, mx1, t1, b1, my1, l3, r3, mx3, t3, b3, my3;

  logic [2:0] mem [64];

  int n_pass = 0, n_total = 0;
  int dcount1 = 0, dcount3 = 0, addr_bad = 0;
  int sel = 0;

  always #5 clk = ~clk;

  star_bbox_finder #(.RD_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .x_i(x_in), .y_i(y_in),
    .rd_addr_o(addr1), .rd_data_i(rd1), .busy_o(busy1), .done_o(done1), .valid_o(valid1),
    .left_o(l1), .right_o(r1), .mid_x_o(mx1), .top_o(t1), .bottom_o(b1), .mid_y_o(my1)
  );

  star_bbox_finder #(.RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .x_i(x_in), .y_i(y_in),
    .rd_addr_o(addr3), .rd_data_i(p3c), .busy_o(busy3), .done_o(done3), .valid_o(valid3),
    .left_o(l3), .right_o(r3), .mid_x_o(mx3), .top_o(t3), .bottom_o(b3), .mid_y_o(my3)
  );

  // RAM models with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    rd1 <= mem[addr1];
    p3a <= mem[addr3];
    p3b <= p3a;
    p3c <= p3b;
    if (done1) dcount1 <= dcount1 + 1;
    if (done3) dcount3 <= dcount3 + 1;
    if ((busy1 && addr1 > 6'd35) || (busy3 && addr3 > 6'd35)) addr_bad <= addr_bad + 1;
  end

  logic       o_busy, o_done, o_valid;
  logic [2:0] o_l, o_r, o_mx, o_t, o_b, o_my;
  always_comb begin
    o_busy  = sel != 0 ? busy3  : busy1;
    o_done  = sel != 0 ? done3  : done1;
    o_valid = sel != 0 ? valid3 : valid1;
    o_l     = sel != 0 ? l3     : l1;
    o_r     = sel != 0 ? r3     : r1;
    o_mx    = sel != 0 ? mx3    : mx1;
    o_t     = sel != 0 ? t3     : t1;
    o_b     = sel != 0 ? b3     : b1;
    o_my    = sel != 0 ? my3    : my1;
  end

  typedef struct {
    int img; int x; int y; int n;
    int v; int l; int r; int t; int b; int mx; int my;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // 0: rectangle x1..3 y2..4; 1: corner star x3..5 y3..5; 2: every pixel bright.
  task automatic load_img(input int n);
    for (int i = 0; i < 64; i++) begin
      int px, py;
      px = i % 6;
      py = i / 6;
      mem[i] = 3'd0;
      if (i < 36) begin
        if (n == 0 && px >= 1 && px <= 3 && py >= 2 && py <= 4) mem[i] = 3'd5;
        if (n == 1 && px >= 3 && py >= 3) mem[i] = 3'd1;
        if (n == 2) mem[i] = 3'd7;
      end
    end
  endtask

  task automatic pulse_start(input int d, input int x, input int y);
    x_in = 3'(x);
    y_in = 3'(y);
    if (d != 0) start3 = 1'b1;
    else start1 = 1'b1;
  endtask

  task automatic run_vec(input int d, input vec_t v, input string tag);
    int got, lat;
    sel = d;
    load_img(v.img);
    lat = 1 + v.n * ((d != 0 ? 3 : 1) + 1);
    got = 0;
    @(posedge clk); #1;
    pulse_start(d, v.x, v.y);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start3 = 1'b0;
      if (cyc == 1) check({tag, " busy"}, int'(o_busy), v.n > 0 ? 1 : 0);
      if (o_done) begin
        got = cyc;
        break;
      end
    end
    check({tag, " latency"}, got, lat);
    check({tag, " valid"}, int'(o_valid), v.v);
    check({tag, " left"}, int'(o_l), v.l);
    check({tag, " right"}, int'(o_r), v.r);
    check({tag, " top"}, int'(o_t), v.t);
    check({tag, " bottom"}, int'(o_b), v.b);
    check({tag, " mid_x"}, int'(o_mx), v.mx);
    check({tag, " mid_y"}, int'(o_my), v.my);
    @(posedge clk); #1;
    check({tag, " done pulse"}, int'(o_done), 0);
    check({tag, " idle busy"}, int'(o_busy), 0);
  endtask

  initial begin
    int dc, got;
    //          img x  y  n  v  l  r  t  b  mx my
    vt[0] = '{0, 1, 2, 9, 1, 1, 3, 2, 4, 2, 3};   // rectangle, seed top-left
    vt[1] = '{1, 3, 3, 7, 1, 3, 5, 3, 5, 4, 4};   // corner star, right edge of image
    vt[2] = '{0, 4, 1, 1, 0, 3, 5, 3, 5, 4, 4};   // dark seed, box held
    vt[3] = '{0, 6, 0, 0, 0, 3, 5, 3, 5, 4, 4};   // out-of-range seed
    vt[4] = '{0, 3, 4, 9, 1, 1, 3, 2, 4, 2, 3};   // rectangle, seed bottom-right
    vt[5] = '{1, 5, 5, 7, 1, 3, 5, 3, 5, 4, 4};   // seed in bottom-right image corner
    vt[6] = '{2, 0, 0, 11, 1, 0, 5, 0, 5, 2, 2};  // full-frame star from origin
    vt[7] = '{0, 2, 5, 1, 0, 0, 5, 0, 5, 2, 2};   // dark seed on last row

    load_img(0);
    #1;
    check("reset busy", int'(busy1), 0);
    check("reset valid", int'(valid1), 0);
    check("reset addr", int'(addr1), 0);
    check("reset box", int'({l1, r1, mx1, t1, b1, my1}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(0, vt[i], $sformatf("lat1 v%0d", i));
    for (int i = 0; i < 8; i++) run_vec(1, vt[i], $sformatf("lat3 v%0d", i));

    // Reset in the middle of the right-hand scan.
    sel = 0;
    load_img(0);
    @(posedge clk); #1;
    pulse_start(0, 1, 2);
    repeat (4) begin
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    dc = dcount1;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy1), 0);
    check("abort done", int'(done1), 0);
    check("abort valid", int'(valid1), 0);
    check("abort addr", int'(addr1), 0);
    check("abort box", int'({l1, r1, mx1, t1, b1, my1}), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort no done", dcount1 - dc, 0);
    run_vec(0, vt[0], "after abort");

    // Starts while busy and on the done cycle are both ignored.
    load_img(0);
    dc = dcount1;
    got = 0;
    @(posedge clk); #1;
    pulse_start(0, 1, 2);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      start1 = (cyc == 5);
      if (cyc == 5) begin
        x_in = 3'd4;
        y_in = 3'd1;
      end
      if (done1) begin
        got = cyc;
        break;
      end
    end
    check("busy start latency", got, 19);
    pulse_start(0, 4, 1);
    @(posedge clk); #1;
    start1 = 1'b0;
    check("done start busy", int'(busy1), 0);
    repeat (2) @(posedge clk);
    #1;
    check("done start still idle", int'(busy1), 0);
    repeat (20) @(posedge clk);
    #1;
    check("single done", dcount1 - dc, 1);
    check("ignored start valid", int'(valid1), 1);
    check("ignored start box", int'({l1, r1, t1, b1}), int'({3'd1, 3'd3, 3'd2, 3'd4}));

    check("address range", addr_bad, 0);
    check("lat3 done count", dcount3, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/star_bbox_finder.md
Name: star_bbox_finder

Overview:
- Given the seed pixel of a star found by the raster star scanner, finds the star's full bounding box: left, right, top and bottom extremes plus centre.
- Probes a synchronous read-only frame RAM through its own read port.
- Generalises the earlier right/bottom-only finder with parametrised resolution, pixel width, threshold and RAM read latency, all four extremes, and a start/done handshake.
- Sits between the star scanner (supplies the seed) and the star-catalogue writer (consumes the box).

Parameters:
- X_W, 3, x coordinate width
- Y_W, 3, y coordinate width
- ADDR_W, 6, frame RAM address width
- PIX_W, 3, pixel value width
- X_RES, 6, image width in pixels (valid x = 0..X_RES-1)
- Y_RES, 6, image height in pixels (valid y = 0..Y_RES-1)
- THRESHOLD, 0, a pixel is bright iff its value is greater than THRESHOLD (unsigned)
- RD_LAT, 1, RAM read latency in cycles, 1..3

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x_in  in  X_W  seed x, sampled with start
- y_in  in  Y_W  seed y, sampled with start
- rd_addr  out  ADDR_W  frame RAM read address = py*X_RES + px (combinational from probe registers)
- rd_data  in  PIX_W  RAM data, valid RD_LAT cycles after rd_addr
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the box is final
- valid  out  1  box valid (seed was bright); updated with done
- left, right, mid_x  out  X_W  x extremes and (left+right)>>1
- top, bottom, mid_y  out  Y_W  y extremes and (top+bottom)>>1

Behaviour:
- Reset: state IDLE, busy=0, done=0, valid=0, all coordinate outputs 0, probe registers 0. Reset mid-scan aborts immediately with no done pulse.
- Probe cycle: (px,py) is held for RD_LAT+1 cycles. rd_data is evaluated in the final cycle, and the next probe coordinate is loaded on that edge. There is no dead cycle between probes or scans.
- States and transitions:
  - IDLE: on start, capture x0/y0 and go to SEED.
  - SEED: probe (x0,y0). If dark, valid=0 and go to DONE. If bright, go to RIGHT.
  - RIGHT: probe x0+1, x0+2, ... on row y0. right = last bright x. The scan stops at the first dark pixel or after evaluating x=X_RES-1. If x0=X_RES-1, right=x0 with zero probes.
  - LEFT: probe x0-1 down to 0 on row y0. left = last bright x. If x0=0, left=0 with zero probes.
  - DOWN: probe column mid_x from y0+1 up to Y_RES-1. bottom = last bright y. If y0=Y_RES-1, zero probes.
  - UP: probe column mid_x from y0-1 down to 0. top = last bright y. If y0=0, zero probes.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Arithmetic: mid_x and mid_y use (X_W+1)/(Y_W+1)-bit sums, so there is no overflow. The address product is computed at full width and truncated to ADDR_W.
- No probe ever addresses x≥X_RES or y≥Y_RES. Coordinates never wrap.
- Output update: left/right/top/bottom/mid/valid update only at DONE and hold until the next DONE. When valid=0 the box outputs are left unchanged.
- Handshake:
  - start is ignored while busy or done.
  - start in the same cycle as the done pulse is ignored. A new request is accepted only in IDLE, the cycle after done.
- Latency: start→done = 1 + N·(RD_LAT+1) cycles, where N is the total number of probes including the seed.
- Out-of-range seed (x_in≥X_RES or y_in≥Y_RES): no probes; DONE with valid=0 after 1 cycle.

Test Plan:
- 6x6 image, bright rectangle x1..3, y2..4; start with seed (1,2), RD_LAT=1 -> N=9, done at cycle 19, valid=1, left=1, right=3, top=2, bottom=4, mid_x=2, mid_y=3.
- Star touching the corner, bright x3..5, y3..5; seed (3,3) -> right=5 with no address beyond column 5, bottom=5, left=3, top=3. rd_addr never exceeds 35.
- Seed (4,1) on a dark pixel -> done after 1+2=3 cycles, valid=0, previous box outputs unchanged.
- Same rectangle with RD_LAT=3 -> identical box, done at cycle 1+9·4=37. A bench RAM model with 3-cycle delay verifies the sampling point.
- Assert resetn low mid-RIGHT scan -> outputs all 0 immediately, no done pulse. A new start after release completes normally.
- start pulsed while busy, and again on the done cycle -> both ignored. A single done pulse per accepted start.
